// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch stage: state encoding, FIFO entry layout,
// reset constants and a small address helper.
package pipeline_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // RUN issues and accepts responses; FLUSH only drops stale responses.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // One decoded-side entry: the instruction word and its address + 4.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_add4;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port, the decode port and the redirect input
// of the fetch stage.
//
// Handshakes:
//   imem: a request transfers when imem_req && imem_gnt at a rising edge; while
//   imem_req is high without imem_gnt, imem_addr is held stable (only a redirect
//   may withdraw it). gnt without req means nothing. Responses are one
//   imem_rvalid pulse per transferred request, returned in request order.
//   decode: an instruction transfers when id_valid && id_ready at a rising edge;
//   id_valid never depends on id_ready.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc_add4;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Fetch-stage view.
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc_add4,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
  );

  // Environment view (memory, decode and branch resolution).
  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc_add4,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear. The head word is read straight
// from storage, so a word pushed this cycle becomes visible next cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word
// requests, buffers responses with their PC+4 and hands them to decode.
// A redirect re-steers the PC, flushes buffered work and discards responses
// still in flight.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clock_in,
  input  logic         res,
  fetch_unit_if.master bus,
  output fetch_state_t dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] fifo_count, tag_count;
  logic          started;
  logic          credit_ok, grant, resp_run, pop;
  logic          data_full, data_empty, tag_full, tag_empty;
  fetch_entry_t  push_entry, head;
  logic [31:0]   tag_head;
  logic          unused_fifo_flags;

  assign dbg_state = state;

  // Requests in flight plus buffered words may never exceed the FIFO depth,
  // so every response is guaranteed a slot.
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
  assign bus.imem_req  = started && (state == RUN) && !bus.redirect && credit_ok;
  assign bus.imem_addr = bus.imem_req ? fetch_pc : 32'h0;
  assign grant         = bus.imem_req && bus.imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_run      = (state == RUN) && bus.imem_rvalid && (outstanding != '0);

  assign bus.id_valid   = !data_empty;
  assign bus.id_inst    = data_empty ? NOP_INST : head.inst;
  assign bus.id_pc_add4 = data_empty ? 32'h0 : head.pc_add4;
  // The pop of a redirect cycle is cancelled; decode flushes that instruction.
  assign pop            = bus.id_valid && bus.id_ready && !bus.redirect;

  assign push_entry.inst    = bus.imem_rdata;
  assign push_entry.pc_add4 = tag_head;

  assign unused_fifo_flags = ^{data_full, tag_full, tag_empty, tag_count};

  // Next state and discard count. A redirect in RUN snapshots every request
  // still owed a response; one in FLUSH only re-steers, leaving the count
  // to keep draining.
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    if (state == FLUSH && bus.imem_rvalid && discard != '0)
      discard_nxt = discard - 1'b1;
    if (bus.redirect && state == RUN)
      discard_nxt = outstanding + CW'(grant) - CW'(resp_run);
    state_nxt = (discard_nxt == '0) ? RUN : FLUSH;
  end

  // State register, fetch PC and request accounting.
  always_ff @(posedge clock_in or negedge res) begin
    if (!res) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      discard <= discard_nxt;
      if (bus.redirect) begin
        fetch_pc    <= word_align(bus.redirect_pc);
        outstanding <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        outstanding <= outstanding + CW'(grant) - CW'(resp_run);
      end
    end
  end

  // Prefetch buffer of {instruction, pc+4} toward decode.
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clock_in),
    .rst_n (res),
    .clear (bus.redirect),
    .push  (resp_run),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (data_full),
    .empty (data_empty),
    .count (fifo_count)
  );

  // In-order pc+4 tags, one per granted request awaiting its response.
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clock_in),
    .rst_n (res),
    .clear (bus.redirect),
    .push  (grant),
    .pop   (resp_run),
    .wdata (fetch_pc + 32'd4),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a variable-latency memory model, an
// expected queue of pc+4 values fed from hand-stepped fetch addresses, and
// targeted checks of reset, stall, redirect, wrap and async-reset behaviour.
module tb_fetch_unit;
  import pipeline_pkg::*;

  logic         clk = 1'b0;
  logic         res;
  fetch_state_t dbg_state;
  fetch_unit_if bus ();

  int checks = 0;
  int errors = 0;

  // Scoreboard and memory model state.
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          lat = 1;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          first_gnt_cyc = -1;
  int          first_vld_cyc = -1;
  logic [31:0] last_pop_pc = 32'h0;
  logic [31:0] mon_exp;
  int          snap;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock_in  (clk),
    .res       (res),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Stop granting, let decode drain, and confirm nothing expected is left.
  task automatic quiesce();
    int idle;
    idle = 0;
    bus.imem_gnt = 1'b0;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 60 && idle < 3; i++) begin
      step();
      settle();
      if (pend_addr.size() == 0 && !bus.id_valid) idle++;
      else idle = 0;
    end
    check("drain_done", 32'(idle >= 3), 32'd1);
    check("exp_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = inst_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (res) begin
      if (bus.id_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.id_valid && bus.id_ready && !bus.redirect) begin
        pop_cnt++;
        last_pop_pc = bus.id_pc_add4;
        check("pop_has_exp", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("pc_add4", bus.id_pc_add4, mon_exp);
          check("inst", bus.id_inst, inst_of(mon_exp - 32'd4));
        end
      end
      if (bus.imem_req && bus.imem_gnt) begin
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        check("gnt_addr", bus.imem_addr, exp_addr);
        exp_q.push_back(exp_addr + 32'd4);
        exp_addr = exp_addr + 32'd4;
        pend_addr.push_back(bus.imem_addr);
        pend_due.push_back(cyc + lat);
      end
      if (bus.redirect) begin
        exp_q.delete();
        exp_addr = bus.redirect_pc & ~32'h3;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    res             = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state.
    repeat (3) step();
    settle();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_inst", bus.id_inst, 32'h0);
    check("rst_pc_add4", bus.id_pc_add4, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(RUN));

    // Zero-wait memory streaming: addresses 0,4,8.. checked by the monitor.
    step();
    res          = 1'b1;
    lat          = 1;
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    repeat (10) step();
    check("first_latency", 32'(first_vld_cyc - first_gnt_cyc), 32'd2);
    snap = pop_cnt;
    repeat (8) step();
    check("one_per_cycle", 32'(pop_cnt - snap), 32'd8);

    // Decode stall: FIFO fills and requests stop.
    bus.id_ready = 1'b0;
    repeat (10) step();
    settle();
    check("stall_req", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(bus.id_valid), 32'd1);
    step();
    bus.imem_gnt = 1'b0;
    bus.id_ready = 1'b1;
    snap = pop_cnt;
    repeat (8) step();
    check("fifo_depth_pops", 32'(pop_cnt - snap), 32'd4);
    quiesce();

    // Three-cycle memory, two requests outstanding, then redirect to 0x100.
    lat = 3;
    step();
    bus.imem_gnt = 1'b1;
    step();
    step();
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    settle();
    check("redir_req", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect = 1'b0;
    settle();
    check("flush_state", 32'(dbg_state), 32'(FLUSH));
    check("flush_id_valid", 32'(bus.id_valid), 32'd0);
    check("flush_inst", bus.id_inst, 32'h0);
    step();
    settle();
    check("flush_state2", 32'(dbg_state), 32'(FLUSH));
    step();
    settle();
    check("resume_state", 32'(dbg_state), 32'(RUN));
    check("resume_req", 32'(bus.imem_req), 32'd1);
    check("resume_addr", bus.imem_addr, 32'h100);
    lat          = 1;
    bus.imem_gnt = 1'b1;
    repeat (5) step();
    quiesce();

    // Misaligned redirect target, then wrap past the top of memory.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    step();
    bus.redirect = 1'b0;
    settle();
    check("align_addr", bus.imem_addr, 32'h200);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    settle();
    check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    settle();
    check("wrap_addr", bus.imem_addr, 32'h0);
    quiesce();
    check("wrap_pc_add4", last_pop_pc, 32'h0);

    // Redirect colliding with a pop and a response, two-cycle memory.
    lat          = 2;
    bus.imem_gnt = 1'b1;
    repeat (6) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h400;
    settle();
    check("collide_req", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect = 1'b0;
    settle();
    check("collide_flush", 32'(dbg_state), 32'(FLUSH));
    check("collide_id_valid", 32'(bus.id_valid), 32'd0);
    step();
    settle();
    check("collide_run", 32'(dbg_state), 32'(RUN));
    check("collide_addr", bus.imem_addr, 32'h400);
    repeat (6) step();
    quiesce();

    // Async reset in the middle of a three-deep flush.
    lat = 6;
    bus.imem_gnt = 1'b1;
    repeat (3) step();
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h800;
    step();
    bus.redirect = 1'b0;
    settle();
    check("pre_rst_flush", 32'(dbg_state), 32'(FLUSH));
    #1;
    res = 1'b0;
    exp_q.delete();
    exp_addr = 32'h0;
    #1;
    check("arst_req", 32'(bus.imem_req), 32'd0);
    check("arst_addr", bus.imem_addr, 32'h0);
    check("arst_id_valid", 32'(bus.id_valid), 32'd0);
    check("arst_pc_add4", bus.id_pc_add4, 32'h0);
    check("arst_state", 32'(dbg_state), 32'(RUN));
    step();
    res = 1'b1;
    repeat (6) step();
    settle();
    check("stale_gone", 32'(pend_addr.size()), 32'd0);
    check("post_rst_req", 32'(bus.imem_req), 32'd1);
    check("post_rst_addr", bus.imem_addr, 32'h0);
    check("post_rst_valid", 32'(bus.id_valid), 32'd0);
    lat          = 1;
    bus.imem_gnt = 1'b1;
    repeat (6) step();
    quiesce();
    check("post_rst_last", last_pop_pc, exp_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
